// File: rtl/pc_unit_pkg.sv
// Shared defaults and helpers for the multithreaded PC unit.
// Imported by the round-robin arbiter and the pc_unit_mt top.
package pc_unit_pkg;

  localparam int              DEFAULT_PC_WIDTH    = 64;
  localparam int              DEFAULT_NUM_THREADS = 4;
  localparam int unsigned     DEFAULT_STEP        = 1;
  localparam longint unsigned DEFAULT_RESET_PC    = 64'd0;

  // Ceiling log2, used to size thread-id fields; returns at least 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/pc_unit_mt_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting thread
// at or after the pointer, wrapping cyclically. NUM_THREADS is a power of two.
module rr_arbiter
  import pc_unit_pkg::*;
#(
  parameter  int NUM_THREADS = DEFAULT_NUM_THREADS,
  localparam int TID_W       = clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] i_request,
  input  logic [TID_W-1:0]       i_ptr,
  output logic [TID_W-1:0]       o_grant,
  output logic                   o_any_grant
);

  logic [TID_W-1:0] w_idx;

  // NOTE: every signal driven in always_comb gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    o_grant     = '0;
    o_any_grant = |i_request;
    w_idx       = '0;
    // Walk offsets from far to near so the nearest requester is assigned last.
    // The pointer sum wraps naturally because the thread count is a power of two.
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      w_idx = i_ptr + TID_W'(i);
      if (i_request[w_idx]) o_grant = w_idx;
    end
  end

endmodule

// File: rtl/pc_unit_mt.sv
// Multithreaded program-counter unit: one PC per hardware thread, round-robin
// issue of one PC per cycle, per-thread branch redirect, registered outputs.
module pc_unit_mt
  import pc_unit_pkg::*;
#(
  parameter  int                  PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter  int                  NUM_THREADS = DEFAULT_NUM_THREADS,
  parameter  int unsigned         STEP        = DEFAULT_STEP,
  parameter  logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC),
  localparam int                  TID_W       = clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   stall,
  input  logic [NUM_THREADS-1:0] thread_active,
  input  logic                   branch_valid,
  input  logic [TID_W-1:0]       branch_tid,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [TID_W-1:0]       tid_out,
  output logic                   pc_valid
);

  logic [PC_WIDTH-1:0] r_pc      [NUM_THREADS];
  logic [PC_WIDTH-1:0] w_pc_next [NUM_THREADS];
  logic [TID_W-1:0]    r_rr_ptr;
  logic [TID_W-1:0]    w_grant;
  logic                w_any_grant;
  logic                w_issue;

  rr_arbiter #(
    .NUM_THREADS (NUM_THREADS)
  ) u_rr_arbiter (
    .i_request   (thread_active),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_any_grant (w_any_grant)
  );

  assign w_issue = enable && !stall && w_any_grant;

  // The branch check comes last so a redirect overrides the increment
  // when both target the same thread in the same cycle.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_pc_next[t] = r_pc[t];
      if (w_issue && (w_grant == TID_W'(t)))
        w_pc_next[t] = r_pc[t] + PC_WIDTH'(STEP);
      if (branch_valid && (branch_tid == TID_W'(t)))
        w_pc_next[t] = branch_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; pc_out below must capture the old PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the PC file is a handful of flops, not a RAM macro, so it is
      // safe and required to clear it on the asynchronous reset.
      for (int t = 0; t < NUM_THREADS; t++) r_pc[t] <= RESET_PC;
      r_rr_ptr <= '0;
      pc_out   <= RESET_PC;
      tid_out  <= '0;
      pc_valid <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_issue) begin
        pc_out   <= r_pc[w_grant];
        tid_out  <= w_grant;
        pc_valid <= 1'b1;
        r_rr_ptr <= w_grant + TID_W'(1);
      end else begin
        pc_valid <= 1'b0;
      end
    end
  end

endmodule
